uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares the single uart_tx transmitter among NREQ byte producers (e.g. CPU register path, debug monitor, trap logger).
- Captures one byte from the granted requester and drives tx_start/d_tx to the transmitter.
- Holds tx_start long enough to be seen in the tx_tick domain, waits for tx_done, then inserts a programmable inter-frame gap.
- Sits between the producers and uart_tx, in place of a direct register-driven tx_start.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_sched.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-scheduler state encoding and baud divisor width.
package uart_pkg;

    localparam int unsigned UART_DVSR_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } tx_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at (ptr+1) mod NREQ, wrapping, and returns the first set bit.
// Ports:
//   req          - request vector
//   ptr          - index of the last winner (search starts just after it)
//   grant_onehot - one-hot winner, all zero when no request
//   grant_idx    - binary index of the winner (0 when no request)
//   any          - at least one request present
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // First set bit after ptr, wrapping around.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any                = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte producers.
// Grants one requester, holds tx_start for dvsr+2 cycles so a tx_tick edge sees it,
// waits for a rising edge of tx_done, then idles GAP_CYCLES before the next grant.
// Optional macro UART_TX_SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog (TIMEOUT_CYCLES)
// that aborts to IDLE and sets the sticky timeout_err flag.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   req_valid   - per-requester byte available
//   req_data    - requester i byte at [i*DBIT +: DBIT]
//   req_ready   - combinational one-hot pulse: byte of requester i captured this cycle
//   dvsr        - live baud divisor
//   tx_start    - start request to uart_tx
//   tx_data     - byte to uart_tx
//   tx_done     - uart_tx done, already synchronised to clk
//   busy        - scheduler not idle
//   grant_id    - index of last granted requester
//   timeout_err - sticky watchdog abort flag (0 when the watchdog is compiled out)
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ           = 4,
    parameter  int unsigned DBIT           = 8,
    parameter  int unsigned GAP_CYCLES     = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 2**20,
    localparam int unsigned IW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DBIT-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic [UART_DVSR_W-1:0] dvsr,
    output logic                   tx_start,
    output logic [DBIT-1:0]        tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [IW-1:0]          grant_id,
    output logic                   timeout_err
);

    localparam int unsigned HW       = UART_DVSR_W + 1;
    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_sched_state_e state, state_d;
    logic [HW-1:0]   hold_cnt, hold_cnt_d;
    logic [GW-1:0]   gap_cnt, gap_cnt_d;
    logic [DBIT-1:0] tx_data_d, sel_data;
    logic [IW-1:0]   grant_id_d;
    logic            tx_start_d, busy_d;
    logic            tx_done_q, done_rise;
    logic [NREQ-1:0] arb_onehot;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WW-1:0] wd_cnt, wd_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // grant_id doubles as the round-robin pointer.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req          (req_valid),
        .ptr          (grant_id),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any          (arb_any)
    );

    // Byte of the current arbitration winner.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) sel_data = req_data[i*DBIT +: DBIT];
        end
    end

    assign req_ready = (state == IDLE) ? arb_onehot : '0;
    assign done_rise = tx_done & ~tx_done_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        gap_cnt_d  = gap_cnt;
        tx_data_d  = tx_data;
        grant_id_d = grant_id;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        wd_cnt_d      = wd_cnt;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    state_d    = START;
                    tx_data_d  = sel_data;
                    grant_id_d = arb_idx;
                    hold_cnt_d = '0;
                end
            end
            START: begin
                // >= so a divisor lowered mid-hold still releases tx_start.
                if (hold_cnt >= HW'(dvsr) + HW'(1)) begin
                    state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt + HW'(1);
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    gap_cnt_d = '0;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt + WW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LAST)) state_d = IDLE;
                else gap_cnt_d = gap_cnt + GW'(1);
            end
            default: state_d = IDLE;
        endcase
        tx_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            tx_data   <= '0;
            grant_id  <= IW'(NREQ - 1);
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_cnt_d;
            gap_cnt   <= gap_cnt_d;
            tx_data   <= tx_data_d;
            grant_id  <= grant_id_d;
            tx_start  <= tx_start_d;
            busy      <= busy_d;
            tx_done_q <= tx_done;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wd_cnt        <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed steps plus randomized frames
// checked against a round-robin reference model. Honours UART_TX_SCHED_TIMEOUT_EN.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_valid0;
    logic [31:0] req_data;
    logic [3:0]  req_ready, req_ready0;
    logic [10:0] dvsr;
    logic        tx_start, tx_start0;
    logic [7:0]  tx_data, tx_data0;
    logic        tx_done, tx_done0;
    logic        busy, busy0;
    logic [1:0]  grant_id, grant_id0;
    logic        timeout_err, timeout_err0;

    int n_assert = 0;
    int n_fail   = 0;
    int m_ptr;
    int n, g;
    logic [7:0] d;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(4), .DBIT(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dvsr(dvsr), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_sched #(.NREQ(4), .DBIT(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data),
        .req_ready(req_ready0), .dvsr(dvsr), .tx_start(tx_start0), .tx_data(tx_data0),
        .tx_done(tx_done0), .busy(busy0), .grant_id(grant_id0), .timeout_err(timeout_err0)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester after the last winner, wrapping.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    // One full frame on dut starting at an IDLE negedge with requests set up.
    task automatic do_frame(input int eg, input logic [7:0] ed);
        int cnt;
        #1;
        chk("req_ready_pulse", req_ready, 32'(1 << eg));
        tick();
        m_ptr = eg;
        chk("tx_start_rise", tx_start, 1);
        chk("tx_data_cap", tx_data, ed);
        chk("grant_id", grant_id, eg);
        chk("req_ready_one_cycle", req_ready, 0);
        req_data[eg*8 +: 8] = 8'($urandom);
        cnt = 1;
        tick();
        while (tx_start === 1'b1 && cnt < 4000) begin
            cnt++;
            tick();
        end
        chk("start_len", cnt, 32'(dvsr) + 2);
        chk("tx_data_stable", tx_data, ed);
        chk("busy_wait_done", busy, 1);
        repeat ($urandom_range(0, 3)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("busy_gap", busy, 1);
            chk("no_grant_in_gap", req_ready, 0);
            tick();
        end
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        reset = 1'b0; req_valid = '0; req_valid0 = '0; req_data = '0;
        dvsr = 11'd3; tx_done = 1'b0; tx_done0 = 1'b0; m_ptr = 3;
        repeat (3) tick();

        // Reset values.
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 3);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;
        tick();

        // Single request, dvsr=3: tx_start high 5 cycles.
        req_valid = 4'b0001;
        req_data[7:0] = 8'h55;
        do_frame(0, 8'h55);

        // tx_done high through START is not an edge; only the next rise exits.
        req_valid = 4'b0001;
        req_data[7:0] = 8'h3C;
        tx_done = 1'b1;
        #1 chk("edge_req_ready", req_ready, 1);
        tick();
        req_valid = '0;
        chk("edge_tx_data", tx_data, 8'h3C);
        n = 0;
        while (tx_start === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("edge_start_len", n, 5);
        for (int k = 0; k < 4; k++) begin
            chk("edge_held_high", busy, 1);
            tick();
        end
        tx_done = 1'b0;
        chk("edge_low_1", busy, 1);
        tick();
        chk("edge_low_2", busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("edge_gap_1", busy, 1);
        tick();
        chk("edge_gap_2", busy, 1);
        tick();
        chk("edge_back_idle", busy, 0);
        m_ptr = 0;

        // Pointer returns to NREQ-1 on reset; round robin order 0,1,2,3,0.
        reset = 1'b0;
        #1 chk("rst2_grant_id", grant_id, 3);
        tick();
        reset = 1'b1;
        m_ptr = 3;
        req_valid = 4'hF;
        req_data = 32'hA3A2_A1A0;
        for (int k = 0; k < 5; k++) begin
            do_frame(k % 4, 8'hA0 + 8'(k % 4));
            req_data = 32'hA3A2_A1A0;
        end
        req_valid = '0;
        tick();

        // GAP_CYCLES=0 instance regrants one cycle after the done edge.
        req_valid0 = 4'b0001;
        req_data[7:0] = 8'h5A;
        #1 chk("gap0_first_ready", req_ready0, 1);
        tick();
        chk("gap0_tx_start", tx_start0, 1);
        chk("gap0_tx_data", tx_data0, 8'h5A);
        n = 0;
        while (tx_start0 === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        #1;
        chk("gap0_regrant", req_ready0, 1);
        chk("gap0_busy", busy0, 0);
        req_valid0 = '0;
        tick();

        // Lowering dvsr mid-hold ends START on the next edge.
        dvsr = 11'd6;
        req_valid = 4'b0010;
        g = pick(req_valid, m_ptr);
        #1 chk("dvsr_req_ready", req_ready, 32'(1 << g));
        tick();
        m_ptr = g;
        req_valid = '0;
        repeat (3) tick();
        chk("dvsr_still_start", tx_start, 1);
        dvsr = 11'd0;
        tick();
        chk("dvsr_live_exit", tx_start, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (2) tick();
        chk("dvsr_back_idle", busy, 0);

        // Randomized frames against the round-robin model.
        for (int it = 0; it < 16; it++) begin
            dvsr = 11'($urandom_range(0, 4));
            req_valid = 4'($urandom_range(1, 15));
            req_data = $urandom;
            g = pick(req_valid, m_ptr);
            d = req_data[g*8 +: 8];
            do_frame(g, d);
        end
        req_valid = '0;
        dvsr = 11'd3;
        tick();

        // Reset mid-START drops outputs immediately; requester 0 then beats 2.
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        chk("mid_start_active", tx_start, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        req_valid = 4'b0101;
        tick();
        reset = 1'b1;
        m_ptr = 3;
        g = pick(req_valid, m_ptr);
        do_frame(g, req_data[g*8 +: 8]);
        g = pick(req_valid, m_ptr);
        do_frame(g, req_data[g*8 +: 8]);
        req_valid = '0;
        tick();

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog: 64 cycles in WAIT_DONE, sticky error, then normal service.
        req_valid = 4'b0001;
        tick();
        m_ptr = 0;
        req_valid = '0;
        n = 0;
        while (tx_start === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("wd_pre_err", timeout_err, 0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("wd_len", n, 64);
        chk("wd_err_set", timeout_err, 1);
        tick();
        chk("wd_err_sticky", timeout_err, 1);
        req_valid = 4'b0010;
        g = pick(req_valid, m_ptr);
        do_frame(g, req_data[g*8 +: 8]);
        req_valid = '0;
        chk("wd_err_after_frame", timeout_err, 1);
`else
        chk("no_wd_err", timeout_err, 0);
        chk("no_wd_err0", timeout_err0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
